// File: rtl/mux2_1.sv
// 2:1 mux with a combinational output, a captured copy, and select-switch tracking.
// Optional registered even-parity output o_par is built when MUX2_1_PARITY_EN is defined.
module mux2_1 #(
  parameter int W  = 1,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2*W-1:0]  i,
  input  logic            sel,
  input  logic            in_valid,
  output logic [W-1:0]    o,
  output logic [W-1:0]    o_q,
  output logic            out_valid,
  output logic            sel_sw,
`ifdef MUX2_1_PARITY_EN
  output logic [CW-1:0]   sw_cnt,
  output logic            o_par
`else
  output logic [CW-1:0]   sw_cnt
`endif
);

  logic [W-1:0]  leg1_s;
  logic [W-1:0]  leg0_s;
  logic [W-1:0]  mux_s;
  logic          switch_s;
  logic          cnt_max_s;
  logic [W-1:0]  o_q_r;
  logic          out_valid_r;
  logic          sel_q_r;
  logic          sel_sw_r;
  logic [CW-1:0] sw_cnt_r;

  assign leg1_s = i[2*W-1:W];
  assign leg0_s = i[W-1:0];

  // Ternary keeps an unknown select visible as X instead of silently picking a leg.
  assign mux_s = sel ? leg1_s : leg0_s;
  assign o     = mux_s;

  assign switch_s  = in_valid & (sel != sel_q_r);
  assign cnt_max_s = (sw_cnt_r == {CW{1'b1}});

  // Capture register bank: data, valid, last select, switch pulse and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q_r       <= {W{1'b0}};
      out_valid_r <= 1'b0;
      sel_q_r     <= 1'b0;
      sel_sw_r    <= 1'b0;
      sw_cnt_r    <= {CW{1'b0}};
    end else begin
      out_valid_r <= in_valid;
      sel_sw_r    <= switch_s;
      if (in_valid) begin
        o_q_r   <= mux_s;
        sel_q_r <= sel;
      end else begin
        o_q_r   <= o_q_r;
        sel_q_r <= sel_q_r;
      end
      if (switch_s && !cnt_max_s) begin
        sw_cnt_r <= sw_cnt_r + CW'(1'b1);
      end else begin
        sw_cnt_r <= sw_cnt_r;
      end
    end
  end

  assign o_q       = o_q_r;
  assign out_valid = out_valid_r;
  assign sel_sw    = sel_sw_r;
  assign sw_cnt    = sw_cnt_r;

`ifdef MUX2_1_PARITY_EN
  logic o_par_r;

  function automatic logic even_par(input logic [W-1:0] d);
    return ^d;
  endfunction

  // Parity is computed from the mux result so it lands in the same cycle as o_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_par_r <= 1'b0;
    end else if (in_valid) begin
      o_par_r <= even_par(mux_s);
    end else begin
      o_par_r <= o_par_r;
    end
  end

  assign o_par = o_par_r;
`endif

endmodule

// File: tb/tb_mux2_1.sv
// Bench for mux2_1: comb vector table, scoreboarded capture sequences, async reset,
// counter saturation (CW=2 instance) and an eight-instance W=1 bus.
module tb_mux2_1;

  logic       clk;
  logic       rst_n;
  logic [7:0] i;
  logic [1:0] i1;
  logic       sel;
  logic       in_valid;

  logic [3:0] o, o_q, s_o, s_oq;
  logic       out_valid, sel_sw, s_ov, s_sw;
  logic [7:0] sw_cnt;
  logic [1:0] s_cnt;
  logic       w_o, w_oq, w_ov, w_sw;
  logic [7:0] w_cnt;
  logic       o_par, s_par, w_par;

  logic [7:0] bl1, bl0, bo, bq, bv, bs;
  logic [7:0] bc [8];
  logic [7:0] bp;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MUX2_1_PARITY_EN
  mux2_1 #(.W(4), .CW(8)) u_dut (.clk(clk), .rst_n(rst_n), .i(i), .sel(sel), .in_valid(in_valid),
    .o(o), .o_q(o_q), .out_valid(out_valid), .sel_sw(sel_sw), .sw_cnt(sw_cnt), .o_par(o_par));
  mux2_1 #(.W(4), .CW(2)) u_sat (.clk(clk), .rst_n(rst_n), .i(i), .sel(sel), .in_valid(in_valid),
    .o(s_o), .o_q(s_oq), .out_valid(s_ov), .sel_sw(s_sw), .sw_cnt(s_cnt), .o_par(s_par));
  mux2_1 u_w1 (.clk(clk), .rst_n(rst_n), .i(i1), .sel(sel), .in_valid(in_valid),
    .o(w_o), .o_q(w_oq), .out_valid(w_ov), .sel_sw(w_sw), .sw_cnt(w_cnt), .o_par(w_par));
`else
  mux2_1 #(.W(4), .CW(8)) u_dut (.clk(clk), .rst_n(rst_n), .i(i), .sel(sel), .in_valid(in_valid),
    .o(o), .o_q(o_q), .out_valid(out_valid), .sel_sw(sel_sw), .sw_cnt(sw_cnt));
  mux2_1 #(.W(4), .CW(2)) u_sat (.clk(clk), .rst_n(rst_n), .i(i), .sel(sel), .in_valid(in_valid),
    .o(s_o), .o_q(s_oq), .out_valid(s_ov), .sel_sw(s_sw), .sw_cnt(s_cnt));
  mux2_1 u_w1 (.clk(clk), .rst_n(rst_n), .i(i1), .sel(sel), .in_valid(in_valid),
    .o(w_o), .o_q(w_oq), .out_valid(w_ov), .sel_sw(w_sw), .sw_cnt(w_cnt));
  assign o_par = 1'b0;
  assign s_par = 1'b0;
  assign w_par = 1'b0;
`endif

  for (genvar k = 0; k < 8; k++) begin : g_bus
`ifdef MUX2_1_PARITY_EN
    mux2_1 u_b (.clk(clk), .rst_n(rst_n), .i({bl1[k], bl0[k]}), .sel(sel), .in_valid(in_valid),
      .o(bo[k]), .o_q(bq[k]), .out_valid(bv[k]), .sel_sw(bs[k]), .sw_cnt(bc[k]), .o_par(bp[k]));
`else
    mux2_1 u_b (.clk(clk), .rst_n(rst_n), .i({bl1[k], bl0[k]}), .sel(sel), .in_valid(in_valid),
      .o(bo[k]), .o_q(bq[k]), .out_valid(bv[k]), .sel_sw(bs[k]), .sw_cnt(bc[k]));
    assign bp[k] = 1'b0;
`endif
  end

  typedef struct {
    logic [7:0] i;
    logic       sel;
    logic [3:0] o;
    logic [1:0] i1;
    logic       o1;
  } comb_vec_t;

  typedef struct {
    logic [3:0] oq;
    logic       ov;
    logic       sw;
    int         c8;
    int         c2;
    logic       par;
  } exp_t;

  exp_t sbq[$];

  // reference model state
  logic [3:0] m_oq;
  logic       m_selq;
  int         m_c8;
  int         m_c2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_oq   = 4'h0;
    m_selq = 1'b0;
    m_c8   = 0;
    m_c2   = 0;
  endtask

  task automatic cap(input logic [7:0] iv, input logic s, input logic v);
    exp_t       e;
    logic [3:0] mux;
    logic       sw;
    @(negedge clk);
    i = iv; sel = s; in_valid = v;
    mux = s ? iv[7:4] : iv[3:0];
    #1 check("o_comb", {28'd0, o}, {28'd0, mux});
    sw = 1'b0;
    if (v) begin
      sw = (s != m_selq);
      if (sw && m_c8 != 255) m_c8++;
      if (sw && m_c2 != 3) m_c2++;
      m_oq   = mux;
      m_selq = s;
    end
    e.oq = m_oq; e.ov = v; e.sw = sw; e.c8 = m_c8; e.c2 = m_c2; e.par = ^m_oq;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      check("o_q", {28'd0, o_q}, {28'd0, e.oq});
      check("out_valid", {31'd0, out_valid}, {31'd0, e.ov});
      check("sel_sw", {31'd0, sel_sw}, {31'd0, e.sw});
      check("sw_cnt", {24'd0, sw_cnt}, e.c8);
      check("sw_cnt_cw2", {30'd0, s_cnt}, e.c2);
`ifdef MUX2_1_PARITY_EN
      check("o_par", {31'd0, o_par}, {31'd0, e.par});
`endif
    end
  endtask

  initial begin
    comb_vec_t tbl [5];
    tbl[0] = '{i: 8'hA5, sel: 1'b1, o: 4'hA, i1: 2'b10, o1: 1'b1};
    tbl[1] = '{i: 8'hA5, sel: 1'b0, o: 4'h5, i1: 2'b10, o1: 1'b0};
    tbl[2] = '{i: 8'h3C, sel: 1'b1, o: 4'h3, i1: 2'b01, o1: 1'b0};
    tbl[3] = '{i: 8'h3C, sel: 1'b0, o: 4'hC, i1: 2'b01, o1: 1'b1};
    tbl[4] = '{i: 8'hF0, sel: 1'b1, o: 4'hF, i1: 2'b11, o1: 1'b1};

    rst_n = 1'b0; i = 8'h00; i1 = 2'b00; sel = 1'b0; in_valid = 1'b0;
    bl1 = 8'h00; bl0 = 8'h00;
    model_reset();
    #3;
    check("rst_o_q", {28'd0, o_q}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sel_sw", {31'd0, sel_sw}, 32'd0);
    check("rst_sw_cnt", {24'd0, sw_cnt}, 32'd0);
`ifdef MUX2_1_PARITY_EN
    check("rst_o_par", {31'd0, o_par}, 32'd0);
`endif

    // comb path is exercised while still in reset
    for (int n = 0; n < 5; n++) begin
      i = tbl[n].i; i1 = tbl[n].i1; sel = tbl[n].sel;
      #1;
      check("comb_w4", {28'd0, o}, {28'd0, tbl[n].o});
      check("comb_w1", {31'd0, w_o}, {31'd0, tbl[n].o1});
    end

    bl1 = 8'b10110101; bl0 = 8'b00011010;
    sel = 1'b0; #1 check("bus_sel0", {24'd0, bo}, 32'h1A);
    sel = 1'b1; #1 check("bus_sel1", {24'd0, bo}, 32'hB5);

    @(negedge clk);
    sel = 1'b0;
    rst_n = 1'b1;

    cap(8'hA5, 1'b1, 1'b1);
    cap(8'h3C, 1'b0, 1'b0);
    cap(8'hB7, 1'b1, 1'b1);
    cap(8'h5A, 1'b0, 1'b1);

    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_o_q", {28'd0, o_q}, 32'd0);
    check("arst_sw_cnt", {24'd0, sw_cnt}, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef MUX2_1_PARITY_EN
    check("arst_o_par", {31'd0, o_par}, 32'd0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    cap(8'hA5, 1'b1, 1'b1);
    cap(8'h12, 1'b0, 1'b1);
    cap(8'h34, 1'b1, 1'b1);
    cap(8'h56, 1'b0, 1'b1);
    cap(8'h78, 1'b1, 1'b1);
    cap(8'h9A, 1'b0, 1'b1);
    cap(8'hBC, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      cap(8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
